bip_control: RTL
================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 SHALL have parameters: NB_OPCODE, 5, opcode width; NB_OPERANDO, 11, operand width; NB_INSTR, 16, instruction width; NB_PC, 11, program-counter width; NB_COUNT, 32, cycle-counter width; NB_DECODER_SEL_A, 2, selA width.
REQ-002 SHALL have ports:
  i_clk  in  1  clock, all state on rising edge
  i_rst  in  1  reset, synchronous, active-low
  i_start  in  1  level-sampled run request
  i_instr  in  NB_INSTR  program-memory read data (opcode [15:11], operand [10:0])
  o_pc  out  NB_PC  program-memory address
  o_selA  out  NB_DECODER_SEL_A  datapath accumulator-source select
  o_selB  out  1  datapath ALU operand select
  o_wrAcc  out  1  datapath accumulator write enable
  o_op  out  NB_OPCODE  datapath ALU opcode
  o_operando  out  NB_OPERANDO  immediate / data-memory address
  o_wrRam  out  1  data-memory write enable
  o_rdRam  out  1  data-memory read enable
  o_done  out  1  program halted
  o_clk_count  out  NB_COUNT  cycles spent executing
REQ-003 SHALL treat reset as decided: i_rst synchronous, active-low; clock i_clk.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-005 IDLE: go to FETCH when i_start=1; else stay.
REQ-006 FETCH: drive o_pc; program memory has 1-cycle synchronous read, so i_instr is valid in the following EXEC; always go to EXEC.
REQ-007 EXEC: decode i_instr; if opcode 00000 (HLT) go to HALT with PC unchanged; else go to FETCH with PC+1.
REQ-008 PC SHALL wrap from 2^NB_PC-1 to 0 with no flag.
REQ-009 HALT: o_done=1; on i_start=1 clear PC and cycle counter, go to FETCH; else stay.
REQ-010 o_done SHALL be 1 only in HALT.
REQ-011 Decode in EXEC (selA/selB/wrAcc/rdRam/wrRam): HLT 00000 -> 0/0/0/0/0; STO 00001 -> 0/0/0/0/1; LD 00010 -> 00/0/1/1/0; LDI 00011 -> 01/0/1/0/0; ADD 00100 -> 10/0/1/1/0; ADDI 00101 -> 10/1/1/0/0; SUB 00110 -> 10/0/1/1/0; SUBI 00111 -> 10/1/1/0/0.
REQ-012 Opcodes 01000-11111 SHALL execute as NOP: all enables 0, PC+1.
REQ-013 In EXEC, o_op=i_instr[15:11] and o_operando=i_instr[10:0]; in all other states, o_op, o_operando, o_selA, o_selB, o_wrAcc, o_wrRam, o_rdRam SHALL be 0.
REQ-014 Decode outputs SHALL be combinational from state and i_instr; data memory is asynchronous read, so every instruction completes in exactly 2 cycles (FETCH+EXEC).
REQ-015 o_clk_count SHALL increment by 1 in every FETCH or EXEC cycle, hold in IDLE/HALT, and wrap at 2^NB_COUNT.
REQ-016 i_start SHALL be ignored in FETCH and EXEC.

Reset
REQ-017 On i_rst=0 at a clock edge: state=IDLE, PC=0, o_clk_count=0, o_done=0, all decode outputs 0; this SHALL take effect from any state, including mid-instruction (a pending EXEC write is dropped).
REQ-018 Reset SHALL take priority over i_start.

Structure
REQ-019 Opcode localparams (HLT..SUBI), selA encodings (00 data, 01 operand, 10 ALU) and state encodings SHALL live in a shared bip package, also used by datapath.
REQ-020 Instruction decode SHALL be a separate combinational sub-module, bip_decoder (opcode in; selA/selB/wrAcc/wrRam/rdRam out); PC, counter and FSM stay in bip_control.

Verification
REQ-021 Reset, then start pulse, program {LDI 5, ADDI 3, STO 2, HLT} -> cycle 2: o_wrAcc=1, o_selA=01, o_operando=5; cycle 6: o_wrRam=1, o_operando=2; o_done=1 after 8 cycles; o_clk_count=8; o_pc=3.
REQ-022 Each opcode 00000-00111 in EXEC -> enables exactly per REQ-011 table; opcode 01010 -> all enables 0, PC advances.
REQ-023 Preload PC to 2047 via 2047 NOP instructions -> next fetch at o_pc=0, no halt.
REQ-024 Assert i_rst=0 during EXEC of STO -> o_wrRam=0 next cycle, state IDLE, o_pc=0, o_clk_count=0.
REQ-025 In HALT, i_start=1 -> o_done=0 next cycle, o_pc=0, o_clk_count restarts from 0; i_start toggled during RUN -> no effect.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: opcode values, accumulator-source
// select encodings and control FSM states. Used by bip_control, bip_decoder
// and the datapath.
package bip_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  // Accumulator source: data memory, instruction operand, ALU result
  localparam logic [1:0] SELA_DATA = 2'b00;
  localparam logic [1:0] SELA_OPER = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } bip_state_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder for the BIP datapath controls.
// Ports:
//   i_opcode  instruction opcode
//   o_selA    accumulator source select
//   o_selB    ALU operand select (1 = immediate operand)
//   o_wrAcc   accumulator write enable
//   o_wrRam   data-memory write enable
//   o_rdRam   data-memory read enable
// Unassigned opcodes decode to NOP (all enables low).
module bip_decoder
  import bip_pkg::*;
#(
  parameter int NB_OPCODE        = 5,
  parameter int NB_DECODER_SEL_A = 2
) (
  input  logic [NB_OPCODE-1:0]        i_opcode,
  output logic [NB_DECODER_SEL_A-1:0] o_selA,
  output logic                        o_selB,
  output logic                        o_wrAcc,
  output logic                        o_wrRam,
  output logic                        o_rdRam
);

  always_comb begin
    o_selA  = '0;
    o_selB  = 1'b0;
    o_wrAcc = 1'b0;
    o_wrRam = 1'b0;
    o_rdRam = 1'b0;
    case (i_opcode)
      OP_STO: o_wrRam = 1'b1;
      OP_LD: begin
        o_selA  = SELA_DATA;
        o_wrAcc = 1'b1;
        o_rdRam = 1'b1;
      end
      OP_LDI: begin
        o_selA  = SELA_OPER;
        o_wrAcc = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        o_selA  = SELA_ALU;
        o_wrAcc = 1'b1;
        o_rdRam = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        o_selA  = SELA_ALU;
        o_selB  = 1'b1;
        o_wrAcc = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: FETCH/EXEC sequencing, program counter and run-cycle
// counter. Program memory has a one-cycle synchronous read, so the word
// addressed during FETCH is decoded in the following EXEC cycle.
// Ports:
//   i_clk        clock (rising edge)
//   i_rst        synchronous active-low reset
//   i_start      run request, sampled in IDLE and HALT only
//   i_instr      program-memory read data {opcode, operand}
//   o_pc         program-memory address
//   o_selA/o_selB/o_wrAcc/o_op/o_operando/o_wrRam/o_rdRam
//                datapath controls, non-zero only in EXEC
//   o_done       high while halted
//   o_clk_count  cycles spent in FETCH/EXEC
module bip_control
  import bip_pkg::*;
#(
  parameter int NB_OPCODE        = 5,
  parameter int NB_OPERANDO      = 11,
  parameter int NB_INSTR         = 16,
  parameter int NB_PC            = 11,
  parameter int NB_COUNT         = 32,
  parameter int NB_DECODER_SEL_A = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [NB_INSTR-1:0]         i_instr,
  output logic [NB_PC-1:0]            o_pc,
  output logic [NB_DECODER_SEL_A-1:0] o_selA,
  output logic                        o_selB,
  output logic                        o_wrAcc,
  output logic [NB_OPCODE-1:0]        o_op,
  output logic [NB_OPERANDO-1:0]      o_operando,
  output logic                        o_wrRam,
  output logic                        o_rdRam,
  output logic                        o_done,
  output logic [NB_COUNT-1:0]         o_clk_count
);

  bip_state_t r_state;
  bip_state_t w_next;
  logic [NB_PC-1:0]    r_pc;
  logic [NB_COUNT-1:0] r_count;

  logic [NB_OPCODE-1:0]        w_opcode;
  logic [NB_DECODER_SEL_A-1:0] w_selA;
  logic                        w_selB;
  logic                        w_wrAcc;
  logic                        w_wrRam;
  logic                        w_rdRam;

  assign w_opcode = i_instr[NB_INSTR-1 -: NB_OPCODE];

  bip_decoder #(
    .NB_OPCODE       (NB_OPCODE),
    .NB_DECODER_SEL_A(NB_DECODER_SEL_A)
  ) u_decoder (
    .i_opcode(w_opcode),
    .o_selA  (w_selA),
    .o_selB  (w_selB),
    .o_wrAcc (w_wrAcc),
    .o_wrRam (w_wrRam),
    .o_rdRam (w_rdRam)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_FETCH: r_count <= r_count + NB_COUNT'(1);
        ST_EXEC: begin
          r_count <= r_count + NB_COUNT'(1);
          // HLT leaves the PC on the halting instruction
          if (w_opcode != OP_HLT) r_pc <= r_pc + NB_PC'(1);
        end
        ST_HALT: begin
          if (i_start) begin
            r_pc    <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_FETCH;
      ST_FETCH: w_next = ST_EXEC;
      ST_EXEC:  w_next = (w_opcode == OP_HLT) ? ST_HALT : ST_FETCH;
      ST_HALT:  if (i_start) w_next = ST_FETCH;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_selA     = '0;
    o_selB     = 1'b0;
    o_wrAcc    = 1'b0;
    o_op       = '0;
    o_operando = '0;
    o_wrRam    = 1'b0;
    o_rdRam    = 1'b0;
    if (r_state == ST_EXEC) begin
      o_selA     = w_selA;
      o_selB     = w_selB;
      o_wrAcc    = w_wrAcc;
      o_op       = w_opcode;
      o_operando = i_instr[NB_OPERANDO-1:0];
      o_wrRam    = w_wrRam;
      o_rdRam    = w_rdRam;
    end
  end

  assign o_done      = (r_state == ST_HALT);
  assign o_pc        = r_pc;
  assign o_clk_count = r_count;

endmodule
